// File: rtl/byte_serial_adder32.sv
// byte_serial_adder32
//   Multi-cycle WIDTH-bit adder. It accepts full-width operands over a
//   valid/ready handshake. It adds one SLICE_W-bit slice per clock,
//   starting with the least significant slice, through a single ripple-carry
//   slice. The assembled sum and carry-out are then presented over a second
//   valid/ready handshake.
//
//   Optional feature macro: OVF_FLAG_EN adds the signed-overflow output ovf.
//
// Parameters
//   WIDTH    total operand width; must be an integer multiple of SLICE_W
//   SLICE_W  bits added per clock (width of the internal adder slice)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, cin are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands, sampled on the accepting edge
//   cin        carry-in to slice 0
//   out_valid  sum/cout (and ovf) are valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        registered WIDTH-bit sum
//   cout       registered carry-out of the top slice
//   ovf        registered signed overflow (only with OVF_FLAG_EN)

module byte_serial_adder32 #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / SLICE_W;
  // A single-slice configuration still needs a 1-bit index register.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx;
  logic               last_slice;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   slice_res;

  assign last_slice = (idx == IDX_W'(N - 1));

  // The single adder slice. Its carry-in comes only from carry_q, so the
  // carry never ripples combinationally from one cycle into the next.
  always_comb begin
    a_sl      = a_q[idx*SLICE_W +: SLICE_W];
    b_sl      = b_q[idx*SLICE_W +: SLICE_W];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_slice) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. The sum is cleared on the accepting edge, so the previous
  // result stays visible for as long as the block idles. cout keeps its
  // value until it is overwritten on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[idx*SLICE_W +: SLICE_W] <= slice_res[SLICE_W-1:0];
          carry_q                       <= slice_res[SLICE_W];
          if (last_slice) begin
            cout_q <= slice_res[SLICE_W];
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OVF_FLAG_EN
  logic ovf_q;

  // Overflow occurs when both operands have the same sign and the sign of
  // the result differs from it. The check uses the MSB of the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last_slice) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
               (slice_res[SLICE_W-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
